// File: rtl/lsu.sv
// Load/store unit: a single-outstanding valid/ready data-memory access with lane
// steering for stores and lane extraction plus extension for loads.
module lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        is_store,
  input  logic [2:0]  mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t      state_q, state_d;
  logic        is_store_q;
  logic [2:0]  op_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        accept;
  logic        illegal;
  logic        misaligned;
  logic        bad;
  logic [31:0] shifted;
  logic [31:0] load_val;
  logic [3:0]  wmask;
  logic [31:0] wdata_lanes;

  // Request checks act on the live inputs because they only matter at the accept edge.
  always_comb begin
    accept     = (state_q == S_IDLE) && req_valid;
    illegal    = 1'b0;
    misaligned = 1'b0;
    if (is_store) begin
      illegal = !((mem_op == 3'b000) || (mem_op == 3'b001) || (mem_op == 3'b010));
    end else begin
      illegal = (mem_op == 3'b011) || (mem_op == 3'b110) || (mem_op == 3'b111);
    end
    case (mem_op[1:0])
      2'b01:   misaligned = addr[0];
      2'b10:   misaligned = (addr[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
    bad = illegal || misaligned;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (req_valid) state_d = bad ? S_RESP : S_REQ;
      S_REQ:  if (mem_req_ready) state_d = is_store_q ? S_RESP : S_WAIT;
      S_WAIT: if (mem_rvalid) state_d = S_RESP;
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    shifted  = mem_rdata >> {addr_q[1:0], 3'b000};
    load_val = shifted;
    case (op_q)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_val = {24'd0, shifted[7:0]};
      3'b101:  load_val = {16'd0, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  always_comb begin
    wmask       = 4'b0000;
    wdata_lanes = wdata_q;
    if (is_store_q) begin
      case (op_q)
        3'b000: begin
          wmask       = 4'b0001 << addr_q[1:0];
          wdata_lanes = {4{wdata_q[7:0]}};
        end
        3'b001: begin
          wmask       = 4'b0011 << addr_q[1:0];
          wdata_lanes = {2{wdata_q[15:0]}};
        end
        default: begin
          wmask       = 4'b1111;
          wdata_lanes = wdata_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      is_store_q <= 1'b0;
      op_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        is_store_q <= is_store;
        op_q       <= mem_op;
        addr_q     <= addr;
        wdata_q    <= wdata;
        rdata_q    <= '0;
        err_q      <= bad;
      end
      if ((state_q == S_WAIT) && mem_rvalid) begin
        rdata_q <= load_val;
      end
    end
  end

  assign req_ready     = (state_q == S_IDLE);
  assign resp_valid    = (state_q == S_RESP);
  assign rdata         = rdata_q;
  assign err           = err_q;
  assign mem_req_valid = (state_q == S_REQ);
  assign mem_addr      = {addr_q[31:2], 2'b00};
  assign mem_wen       = (state_q == S_REQ) && is_store_q;
  assign mem_wmask     = (state_q == S_REQ) ? wmask : 4'b0000;
  assign mem_wdata     = wdata_lanes;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: loads, stores, error paths, backpressure and reset mid-access.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        is_store;
  logic [2:0]  mem_op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        err;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  always #5 clk = ~clk;

  lsu dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .is_store     (is_store),
    .mem_op       (mem_op),
    .addr         (addr),
    .wdata        (wdata),
    .resp_valid   (resp_valid),
    .rdata        (rdata),
    .err          (err),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_addr     (mem_addr),
    .mem_wen      (mem_wen),
    .mem_wmask    (mem_wmask),
    .mem_wdata    (mem_wdata),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for the accept edge, then scramble the inputs.
  task automatic issue(input logic st, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] wd);
    check("req_ready_before_accept", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    is_store  = st;
    mem_op    = op;
    addr      = a;
    wdata     = wd;
    tick();
    req_valid = 1'b0;
    is_store  = ~st;
    mem_op    = 3'b111;
    addr      = 32'hFFFF_FFFF;
    wdata     = 32'h5555_5555;
  endtask

  // Load with immediate handshake; a junk mem_rvalid during REQ must be ignored.
  task automatic do_load(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] word, input logic [31:0] exp);
    issue(1'b0, op, a, 32'h0);
    check({tag, "_req_valid"}, {31'd0, mem_req_valid}, 32'd1);
    check({tag, "_mem_addr"}, mem_addr, {a[31:2], 2'b00});
    mem_req_ready = 1'b1;
    mem_rvalid    = 1'b1;
    mem_rdata     = 32'h1357_9BDF;
    tick();
    mem_req_ready = 1'b0;
    mem_rdata     = word;
    tick();
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    check({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd1);
    check({tag, "_rdata"}, rdata, exp);
    check({tag, "_err"}, {31'd0, err}, 32'd0);
    tick();
  endtask

  task automatic do_bad(input string tag, input logic st, input logic [2:0] op,
                        input logic [31:0] a);
    issue(st, op, a, 32'hA5A5_A5A5);
    check({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd1);
    check({tag, "_err"}, {31'd0, err}, 32'd1);
    check({tag, "_rdata"}, rdata, 32'd0);
    check({tag, "_no_mem_req"}, {31'd0, mem_req_valid}, 32'd0);
    tick();
    check({tag, "_resp_done"}, {31'd0, resp_valid}, 32'd0);
    check({tag, "_no_mem_req2"}, {31'd0, mem_req_valid}, 32'd0);
    check({tag, "_err_hold"}, {31'd0, err}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; is_store = 1'b0; mem_op = '0; addr = '0; wdata = '0;
    mem_req_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wen", {31'd0, mem_wen}, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);

    // lw aligned, read data two cycles after handshake
    issue(1'b0, 3'b010, 32'h8000_0004, 32'h0);
    check("lw_req_valid", {31'd0, mem_req_valid}, 32'd1);
    check("lw_mem_addr", mem_addr, 32'h8000_0004);
    check("lw_wmask", {28'd0, mem_wmask}, 32'd0);
    check("lw_wen", {31'd0, mem_wen}, 32'd0);
    check("lw_req_ready_busy", {31'd0, req_ready}, 32'd0);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    check("lw_wait_no_req", {31'd0, mem_req_valid}, 32'd0);
    tick();
    check("lw_wait_no_resp", {31'd0, resp_valid}, 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEAD_BEEF;
    tick();
    mem_rvalid = 1'b0;
    check("lw_resp_valid", {31'd0, resp_valid}, 32'd1);
    check("lw_rdata", rdata, 32'hDEAD_BEEF);
    check("lw_err", {31'd0, err}, 32'd0);
    tick();
    check("lw_resp_one_cycle", {31'd0, resp_valid}, 32'd0);
    check("lw_rdata_hold", rdata, 32'hDEAD_BEEF);

    do_load("lb3", 3'b000, 32'h0000_0103, 32'h80FF_0000, 32'hFFFF_FF80);
    do_load("lbu3", 3'b100, 32'h0000_0103, 32'h80FF_0000, 32'h0000_0080);
    do_load("lhu2", 3'b101, 32'h0000_0102, 32'h80FF_0000, 32'h0000_80FF);
    do_load("lh2", 3'b001, 32'h0000_0102, 32'h80FF_0000, 32'hFFFF_80FF);
    do_load("lb1", 3'b000, 32'h0000_0101, 32'h1234_7F56, 32'h0000_007F);
    do_load("lh0", 3'b001, 32'h0000_0100, 32'h1234_9ABC, 32'hFFFF_9ABC);

    // sb to offset 3
    issue(1'b1, 3'b000, 32'h0000_1003, 32'h1234_56AB);
    check("sb_wmask", {28'd0, mem_wmask}, 32'h8);
    check("sb_wdata", mem_wdata, 32'hABAB_ABAB);
    check("sb_wen", {31'd0, mem_wen}, 32'd1);
    check("sb_mem_addr", mem_addr, 32'h0000_1000);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    check("sb_resp_valid", {31'd0, resp_valid}, 32'd1);
    check("sb_rdata", rdata, 32'd0);
    check("sb_err", {31'd0, err}, 32'd0);
    tick();

    do_bad("mis_lw", 1'b0, 3'b010, 32'h0000_2002);
    do_bad("mis_lh", 1'b0, 3'b001, 32'h0000_2005);
    do_bad("ill_ld011", 1'b0, 3'b011, 32'h0000_2000);
    do_bad("ill_st100", 1'b1, 3'b100, 32'h0000_2000);
    do_bad("mis_sw", 1'b1, 3'b010, 32'h0000_2001);

    // sh to offset 2 with three cycles of backpressure
    issue(1'b1, 3'b001, 32'h0000_3002, 32'h0000_BEEF);
    for (int i = 0; i < 3; i++) begin
      check("bp_req_valid", {31'd0, mem_req_valid}, 32'd1);
      check("bp_wmask", {28'd0, mem_wmask}, 32'hC);
      check("bp_mem_addr", mem_addr, 32'h0000_3000);
      check("bp_wdata", mem_wdata, 32'hBEEF_BEEF);
      check("bp_no_resp", {31'd0, resp_valid}, 32'd0);
      tick();
    end
    mem_req_ready = 1'b1;
    check("bp_req_valid_hs", {31'd0, mem_req_valid}, 32'd1);
    check("bp_wmask_hs", {28'd0, mem_wmask}, 32'hC);
    tick();
    mem_req_ready = 1'b1;
    check("bp_resp_valid", {31'd0, resp_valid}, 32'd1);
    check("bp_single_hs", {31'd0, mem_req_valid}, 32'd0);
    check("bp_err_cleared", {31'd0, err}, 32'd0);
    tick();
    mem_req_ready = 1'b0;
    check("bp_idle_no_req", {31'd0, mem_req_valid}, 32'd0);

    // reset while waiting for read data
    issue(1'b0, 3'b010, 32'h0000_0040, 32'h0);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rw_req_ready", {31'd0, req_ready}, 32'd1);
    check("rw_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rw_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
    check("rw_rdata", rdata, 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hCAFE_F00D;
    tick();
    mem_rvalid = 1'b0;
    check("rw_late_rvalid_ignored", {31'd0, resp_valid}, 32'd0);
    check("rw_still_idle", {31'd0, req_ready}, 32'd1);
    tick();
    check("rw_no_resp_later", {31'd0, resp_valid}, 32'd0);
    do_load("rw_next_lw", 3'b010, 32'h0000_0048, 32'h0BAD_CAFE, 32'h0BAD_CAFE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit directly downstream of the CPU's ALU. It takes the ALU `sum` as an effective address, with the store data and access type from decode. It runs a valid/ready transaction on the data-memory port and returns a sign- or zero-extended load result, or a completion pulse for stores. It is the first multi-cycle stage in the core: the execute stage stalls while the LSU is busy.

## Interface
- No parameters; address and data are fixed at 32 bits.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  execute stage presents an access.
- `req_ready`  out  1  LSU idle and able to accept.
- `is_store`  in  1  1 = store, 0 = load.
- `mem_op`  in  3  RV32 funct3:
  - loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu
  - stores: 000 sb, 001 sh, 010 sw
- `addr`  in  32  effective address (ALU sum).
- `wdata`  in  32  store data (rs2).
- `resp_valid`  out  1  one-cycle completion pulse.
- `rdata`  out  32  extended load result; 0 for stores and errors.
- `err`  out  1  valid with `resp_valid`; misaligned or illegal `mem_op`.
- `mem_req_valid`  out  1  memory request.
- `mem_req_ready`  in  1  memory accepts the request.
- `mem_addr`  out  32  word-aligned address, `{addr[31:2],2'b00}`.
- `mem_wen`  out  1  write enable.
- `mem_wmask`  out  4  byte-lane strobe; 0000 on loads.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_rvalid`  in  1  read data valid.
- `mem_rdata`  in  32  read word.

## Operation
- States: IDLE, REQ, WAIT, RESP.
- Reset: state IDLE. All outputs 0 except `req_ready`, which is 1. All captured registers are cleared.
- **IDLE:** `req_ready`=1.
  - On `req_valid`, capture `is_store`, `mem_op`, `addr` and `wdata`.
  - Check the access:
    - Illegal: load `mem_op` in {011,110,111}, or store `mem_op` not in {000,001,010}.
    - Misaligned: halfword with `addr[0]`=1, or word with `addr[1:0]`≠00.
  - Illegal or misaligned: go to RESP with `err`=1. No memory request is issued.
  - Otherwise: go to REQ.
- **REQ:** `mem_req_valid`=1. `mem_addr`, `mem_wen`, `mem_wmask` and `mem_wdata` come from the captured registers and stay stable until `mem_req_ready`.
  - Handshake on a store: go to RESP.
  - Handshake on a load: go to WAIT.
  - `mem_rvalid` is ignored in REQ.
- **WAIT:** on `mem_rvalid`, extract the addressed lane from `mem_rdata`, extend it, register it into `rdata`, then go to RESP.
- **RESP:** `resp_valid`=1 for exactly one cycle, then go to IDLE. There is no response backpressure.
- Store lanes, with `o = addr[1:0]`:
  - sb: `mem_wmask` = 0001<<o; `mem_wdata` = {4{wdata[7:0]}}.
  - sh: `mem_wmask` = 0011<<o; `mem_wdata` = {2{wdata[15:0]}}.
  - sw: `mem_wmask` = 1111; `mem_wdata` = wdata.
- Load extraction: shift `mem_rdata` right by 8·`addr[1:0]`, then apply the op:
  - lb: sign-extend bits [7:0].
  - lbu: zero-extend bits [7:0].
  - lh: sign-extend bits [15:0].
  - lhu: zero-extend bits [15:0].
  - lw: the full word.
- `rdata` and `err` hold their values until the next RESP. Both are cleared on IDLE→REQ.

## Timing
- Take cycle 0 as the accept edge (`req_valid` && `req_ready`).
- Error path: `resp_valid` in cycle 1.
- Store: REQ from cycle 1. If `mem_req_ready` arrives in cycle k, `resp_valid` is in cycle k+1. Minimum latency is 2.
- Load: handshake in cycle k, then `mem_rvalid` in cycle j (j > k), then `resp_valid` in cycle j+1. Minimum latency is 3.
- `req_ready` is 0 from cycle 1 until the cycle after RESP. The earliest back-to-back accept is the cycle after `resp_valid`.
- Inputs are sampled only at the accept edge. Changes to them afterwards have no effect.
- Reset in any state takes effect on the next edge: state IDLE, `mem_req_valid`=0, `resp_valid`=0. A pending `mem_rvalid` after reset is ignored.
- Outputs depend only on state and registers. There is no combinational path from `mem_*` inputs to `mem_*` outputs.

## Test plan
- **lw, aligned:** `addr`=0x8000_0004, memory returns 0xDEAD_BEEF with `mem_rvalid` 2 cycles after the handshake.
  - `mem_addr`=0x8000_0004 and `mem_wmask`=0000.
  - `rdata`=0xDEAD_BEEF, `err`=0, `resp_valid` one cycle.
- **lb / lbu, offset 3:** `mem_rdata`=0x80FF_0000.
  - lb returns 0xFFFF_FF80.
  - lbu returns 0x0000_0080.
  - lhu at offset 2 returns 0x0000_80FF.
- **sb, offset 3:** `wdata`=0x1234_56AB.
  - `mem_wmask`=1000, `mem_wdata`=0xABAB_ABAB, `mem_wen`=1.
  - `resp_valid` the cycle after the handshake, `rdata`=0.
- **Misaligned lw:** `addr`=0x...2.
  - `err`=1 and `resp_valid` in cycle 1.
  - `mem_req_valid` never asserts.
  - Same check for lh at an odd address and for `mem_op`=011.
- **Backpressure:** hold `mem_req_ready` low for 3 cycles during sh to offset 2.
  - `mem_req_valid`=1 and `mem_wmask`=1100 stable throughout.
  - `mem_addr` stable throughout.
  - Exactly one handshake.
- **Reset in WAIT:** assert `rst` for 1 cycle, then drive `mem_rvalid`.
  - No `resp_valid`.
  - `req_ready`=1 the cycle after reset.
  - The next request completes normally.
